// File: rtl/aes_stream_pkg.sv
// Shared constants and FSM state type for the frame-memory AES block streamer.
package aes_stream_pkg;
   localparam int BLK_W          = 128;
   localparam int WORD_W         = 1024;
   localparam int BEATS_PER_WORD = WORD_W / BLK_W;
   localparam int MEM_DEPTH      = 3601;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CAPTURE,
      ST_STREAM,
      ST_DONE
   } stream_state_e;
endpackage

// File: rtl/word_serializer.sv
// Holds the active memory word and presents it as consecutive BLK_W-wide beats on a
// valid/ready stream; a load replaces the word and restarts at beat 0.
module word_serializer #(
   parameter int WORD_W = aes_stream_pkg::WORD_W,
   parameter int BLK_W  = aes_stream_pkg::BLK_W,
   parameter int BEAT_W = $clog2(WORD_W / BLK_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic              blk_ready,
   output logic [BLK_W-1:0]  blk_data,
   output logic              blk_valid,
   output logic [BEAT_W-1:0] beat
);
   localparam int BEATS = WORD_W / BLK_W;

   logic [WORD_W-1:0] active;

   always_ff @(posedge clk) begin
      if (reset) begin
         active    <= '0;
         beat      <= '0;
         blk_valid <= 1'b0;
      end else if (load) begin
         active    <= load_data;
         beat      <= '0;
         blk_valid <= 1'b1;
      end else if (blk_valid && blk_ready) begin
         if (beat == BEAT_W'(BEATS - 1)) begin
            beat      <= '0;
            blk_valid <= 1'b0;
         end else begin
            beat <= beat + 1'b1;
         end
      end
   end

   assign blk_data = active[beat*BLK_W +: BLK_W];
endmodule

// File: rtl/aes_mem_block_streamer.sv
// Streams runs of 1024-bit frame-memory words (read over port s2) as 128-bit AES
// blocks, prefetching the next word into a second buffer while the current one drains.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | first read of the run on s2
// CAPTURE | first word on mem_readdata, loaded into the active buffer
// STREAM  | beats flowing; next word prefetched in the background
// DONE    | one-cycle done pulse, busy already low
module aes_mem_block_streamer #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = aes_stream_pkg::MEM_DEPTH,
   parameter int WORD_W = aes_stream_pkg::WORD_W,
   parameter int BLK_W  = aes_stream_pkg::BLK_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_clken,
   input  logic [WORD_W-1:0] mem_readdata,
   output logic [BLK_W-1:0]  blk_data,
   output logic              blk_valid,
   input  logic              blk_ready,
   output logic              blk_last
);
   import aes_stream_pkg::*;

   localparam int BEATS  = WORD_W / BLK_W;
   localparam int BEAT_W = $clog2(BEATS);

   stream_state_e     state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] words_left;
   logic [ADDR_W-1:0] base_mod;
   logic [WORD_W-1:0] pf_buf;
   logic              pf_full;
   logic              pf_cap;
   logic              pf_inflight;
   logic              pf_issue;
   logic              load_pf;
   logic              at_last_beat;
   logic              ser_load;
   logic [WORD_W-1:0] ser_data;
   logic [BEAT_W-1:0] beat;

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   assign mem_write = 1'b0;
   assign mem_clken = 1'b1;

   // An out-of-range base is at most one DEPTH too large for a 12-bit address.
   assign base_mod = (base_addr >= ADDR_W'(DEPTH)) ? base_addr - ADDR_W'(DEPTH) : base_addr;

   assign pf_inflight  = mem_chipselect | pf_cap;
   assign at_last_beat = (beat == BEAT_W'(BEATS - 1));
   assign blk_last     = blk_valid && at_last_beat && (words_left == '0) && !pf_full && !pf_inflight;
   assign pf_issue     = (state == ST_STREAM) && !pf_full && (words_left != '0) && !pf_inflight;
   assign load_pf      = (state == ST_STREAM) && pf_full && (!blk_valid || (blk_ready && at_last_beat));
   assign ser_load     = (state == ST_CAPTURE) || load_pf;
   assign ser_data     = (state == ST_CAPTURE) ? mem_readdata : pf_buf;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         cur_addr       <= '0;
         words_left     <= '0;
         pf_buf         <= '0;
         pf_full        <= 1'b0;
         pf_cap         <= 1'b0;
         mem_address    <= '0;
         mem_chipselect <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         mem_chipselect <= 1'b0;
         done           <= 1'b0;
         pf_cap         <= mem_chipselect && (state == ST_STREAM);

         if (pf_cap) begin
            pf_buf  <= mem_readdata;
            pf_full <= 1'b1;
         end else if (load_pf) begin
            pf_full <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (word_count == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     mem_address    <= base_mod;
                     mem_chipselect <= 1'b1;
                     cur_addr       <= addr_inc(base_mod);
                     words_left     <= word_count - 1'b1;
                     busy           <= 1'b1;
                     state          <= ST_FETCH;
                  end
               end
            end
            ST_FETCH:   state <= ST_CAPTURE;
            ST_CAPTURE: state <= ST_STREAM;
            ST_STREAM: begin
               if (pf_issue) begin
                  mem_address    <= cur_addr;
                  mem_chipselect <= 1'b1;
                  cur_addr       <= addr_inc(cur_addr);
                  words_left     <= words_left - 1'b1;
               end
               if (blk_last && blk_ready) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   word_serializer #(
      .WORD_W (WORD_W),
      .BLK_W  (BLK_W),
      .BEAT_W (BEAT_W)
   ) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .load_data (ser_data),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .beat      (beat)
   );
endmodule

// File: doc/aes_mem_block_streamer.md
Name: aes_mem_block_streamer

Overview:
- Read-side companion to the 1024-bit dual-port on-chip frame memory; drives its second Avalon-MM port (s2) as a read-only master.
- Fetches a run of 1024-bit memory words on command and serializes each word into eight 128-bit AES blocks on a valid/ready stream toward the AES core.
- Prefetches the next word into a second buffer while the current word streams, so bursts run without bubbles.

Parameters:
- ADDR_W, 12, memory word-address width.
- DEPTH, 3601, number of memory words; addresses wrap modulo DEPTH.
- WORD_W, 1024, memory data width.
- BLK_W, 128, AES block width; WORD_W/BLK_W = 8 beats per word.

Ports:
- clk  in  1  single clock for the block and for memory port s2.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command strobe; honoured only when idle.
- base_addr  in  ADDR_W  first word address; must be below DEPTH.
- word_count  in  ADDR_W  number of words to stream (0..DEPTH).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- mem_address  out  ADDR_W  to s2 address.
- mem_chipselect  out  1  to s2 chipselect; high only in read-issue cycles.
- mem_write  out  1  tied 0.
- mem_clken  out  1  tied 1.
- mem_readdata  in  WORD_W  from s2 readdata.
- blk_data  out  BLK_W  AES block.
- blk_valid  out  1  block valid.
- blk_ready  in  1  downstream ready.
- blk_last  out  1  high with the final beat of the final word.

Behaviour:
- Reset values: busy, done, blk_valid, blk_last, and mem_chipselect are 0; mem_address and blk_data are 0; FSM is IDLE; both buffers are empty; all counters are 0.
- Memory timing: the address is registered inside the RAM and its output is unregistered. A read issued in cycle N, with mem_chipselect=1, returns data in cycle N+1, and the streamer captures it at the end of N+1.
- FSM states: IDLE, FETCH, CAPTURE, STREAM, DONE.
- IDLE:
  - start=1 with word_count=0 goes to DONE; no memory access.
  - Otherwise, latch base_addr into cur_addr and word_count into words_left, then go to FETCH.
  - start is ignored in every non-IDLE state.
- FETCH: drive mem_address=cur_addr and mem_chipselect=1 for one cycle. Advance cur_addr, wrapping from DEPTH-1 to 0, and decrement words_left. Go to CAPTURE.
- CAPTURE: load mem_readdata into the active buffer, set beat=0, and go to STREAM.
- Start latency: the first blk_valid is asserted 3 cycles after the start cycle.
- STREAM:
  - blk_data = active[beat*128 +: 128]. Beat 0 is bits [127:0], i.e. byte lanes 0..15.
  - The beat advances only when blk_valid and blk_ready are both high.
  - blk_data and blk_valid hold stable while blk_ready=0.
- Prefetch: in STREAM, if the prefetch buffer is empty, words_left>0, and no prefetch is in flight, issue a read (same rules as FETCH). Capture it into the prefetch buffer the next cycle.
- When beat 7 is accepted:
  - If the prefetch buffer is full, move it to active, set beat=0, and stay in STREAM. The next beat is valid the following cycle with no bubble.
  - Else if words_left>0 or a prefetch is in flight, wait for the capture (blk_valid=0), then continue.
  - Else go to DONE.
- blk_last = blk_valid && beat==7 && words_left==0 && prefetch buffer empty && no prefetch in flight.
- DONE: pulse done=1 for one cycle, drop busy, and return to IDLE the next cycle.
- Wrap-around: base_addr=3600, word_count=2 reads addresses 3600 then 0.
- Reset mid-operation: any in-flight read result is discarded and all state returns to reset values the next cycle. No done pulse is generated.
- Out-of-range base_addr (>= DEPTH) is a caller error; the block reduces it modulo DEPTH.

Decomposition:
- Shared package aes_stream_pkg holds BLK_W, WORD_W, BEATS_PER_WORD=8, MEM_DEPTH=3601, and the FSM state enum.
- One natural sub-module: word_serializer, which holds the 1024-bit active buffer, the beat counter, and the valid/ready output stage. The top level keeps the FSM, address/count logic, and prefetch buffer.

Test Plan:
- Single word: base=5, count=1, memory word 5 = bytes 0x00..0x7F, blk_ready=1 → 8 beats starting 3 cycles after start. Beat 0 = 0x0F0E..0100, beat 7 = 0x7F7E..7170. blk_last on beat 7; done 1 cycle later.
- Back-to-back: base=0, count=4, ready=1 → 32 consecutive valid beats with no bubble after the first. Exactly 4 chipselect cycles at addresses 0,1,2,3.
- Backpressure: count=2, blk_ready toggling 1,0,0,1… → blk_data/blk_valid stable during stalls. 16 beats delivered in order; no extra memory reads.
- Wrap and zero count: base=3600, count=2 → reads at 3600 then 0. Separately, count=0 → done 1 cycle after start, no chipselect, no blk_valid.
- Reset mid-stream: assert reset on beat 3 of word 1 of a 3-word run → next cycle busy=0, blk_valid=0, no done. A new start with base=10, count=1 then streams correctly.
- Start while busy: pulse start again during STREAM with different base → ignored; the original run completes unchanged.
